// File: rtl/key_debounce_array_if.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_array_if
// Description : Key-array signal bundle: raw key inputs in, debounced level
//               and event pulses out.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_debounce_array_if #(
  parameter int CHANNELS = 4
);
  // "release" is a reserved word, so the release pulse carries a suffix.
  logic [CHANNELS-1:0] in;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] press;
  logic [CHANNELS-1:0] release_pulse;
  logic [CHANNELS-1:0] hold;

  modport slave (
    input  in,
    output level,
    output press,
    output release_pulse,
    output hold
  );

  modport master (
    output in,
    input  level,
    input  press,
    input  release_pulse,
    input  hold
  );
endinterface
`default_nettype wire

// File: rtl/key_debounce_array.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_array
// Description : Multi-channel key debouncer with press/release one-shots and
//               long-press hold detection with optional auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_array #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 15,
  parameter int ACTIVE_LOW      = 0,
  parameter int HOLD_CYCLES     = 1000,
  parameter int REPEAT_CYCLES   = 200,
  parameter int REPEAT_EN       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  key_debounce_array_if.slave   bus
);

  localparam int C_CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int C_HMAX   = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int C_HCNT_W = $clog2(C_HMAX + 1);

  localparam logic [C_CNT_W-1:0]  c_cnt_last  = C_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [C_HCNT_W-1:0] c_hold_last = C_HCNT_W'(HOLD_CYCLES - 1);
  localparam logic [C_HCNT_W-1:0] c_rep_last  = C_HCNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CHANNELS-1:0] c_inv       = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic                c_repeat    = (REPEAT_EN != 0);

  generate
    if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
      $error("key_debounce_array: DEBOUNCE_CYCLES, HOLD_CYCLES and REPEAT_CYCLES must be >= 1");
    end
  endgenerate

  logic [CHANNELS-1:0] s1_q, s1_d;
  logic [CHANNELS-1:0] s2_q, s2_d;
  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] press_q, press_d;
  logic [CHANNELS-1:0] release_q, release_d;
  logic [CHANNELS-1:0] hold_q, hold_d;
  logic [CHANNELS-1:0] rep_q, rep_d;
  logic [C_CNT_W-1:0]  cnt_q  [CHANNELS];
  logic [C_CNT_W-1:0]  cnt_d  [CHANNELS];
  logic [C_HCNT_W-1:0] hcnt_q [CHANNELS];
  logic [C_HCNT_W-1:0] hcnt_d [CHANNELS];

  always_comb begin
    s1_d      = bus.in ^ c_inv;
    s2_d      = s1_q;
    level_d   = level_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    rep_d     = rep_q;
    press_d   = '0;
    release_d = '0;
    hold_d    = '0;

    for (int i = 0; i < CHANNELS; i++) begin
      // Any sample agreeing with the current level restarts the count.
      if (s2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == c_cnt_last) begin
        level_d[i] = s2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + C_CNT_W'(1);
      end

      press_d[i]   = level_d[i] & ~level_q[i];
      release_d[i] = ~level_d[i] & level_q[i];

      // rep marks that the first hold pulse has fired; the threshold then
      // switches from the long-press time to the repeat interval.
      if (!level_d[i] || press_d[i]) begin
        hcnt_d[i] = '0;
        rep_d[i]  = 1'b0;
      end else if (rep_q[i] && !c_repeat) begin
        hcnt_d[i] = hcnt_q[i];
      end else if (hcnt_q[i] == (rep_q[i] ? c_rep_last : c_hold_last)) begin
        hold_d[i] = 1'b1;
        hcnt_d[i] = '0;
        rep_d[i]  = 1'b1;
      end else begin
        hcnt_d[i] = hcnt_q[i] + C_HCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      hold_q    <= '0;
      rep_q     <= '0;
      cnt_q     <= '{default: '0};
      hcnt_q    <= '{default: '0};
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      hold_q    <= hold_d;
      rep_q     <= rep_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
    end
  end

  assign bus.level         = level_q;
  assign bus.press         = press_q;
  assign bus.release_pulse = release_q;
  assign bus.hold          = hold_q;

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_debounce_array
// Description : Directed self-checking bench for key_debounce_array.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_debounce_array;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  key_debounce_array_if #(.CHANNELS(4)) a_if ();
  key_debounce_array_if #(.CHANNELS(4)) b_if ();
  key_debounce_array_if #(.CHANNELS(4)) c_if ();

  // Repeat-disabled variant sees exactly the same key activity as dut_a.
  assign b_if.in = a_if.in;

  key_debounce_array #(
    .CHANNELS(4), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(0),
    .HOLD_CYCLES(20), .REPEAT_CYCLES(8), .REPEAT_EN(1)
  ) dut_a (.clk(clk), .rst(rst), .bus(a_if));

  key_debounce_array #(
    .CHANNELS(4), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(0),
    .HOLD_CYCLES(20), .REPEAT_CYCLES(8), .REPEAT_EN(0)
  ) dut_b (.clk(clk), .rst(rst), .bus(b_if));

  key_debounce_array #(
    .CHANNELS(4), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1),
    .HOLD_CYCLES(20), .REPEAT_CYCLES(8), .REPEAT_EN(1)
  ) dut_c (.clk(clk), .rst(rst), .bus(c_if));

  task automatic test_reset();
    rst     = 1'b1;
    a_if.in = 4'h0;
    c_if.in = 4'hF;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1;
      tests++;
      if ({a_if.level, a_if.press, a_if.release_pulse, a_if.hold,
           b_if.level, b_if.press, b_if.release_pulse, b_if.hold,
           c_if.level, c_if.press, c_if.release_pulse, c_if.hold} !== 48'h0) begin
        fails++;
        $display("FAIL reset edge %0d: a=%h/%h/%h/%h b=%h/%h/%h/%h c=%h/%h/%h/%h expected all 0",
                 e, a_if.level, a_if.press, a_if.release_pulse, a_if.hold,
                 b_if.level, b_if.press, b_if.release_pulse, b_if.hold,
                 c_if.level, c_if.press, c_if.release_pulse, c_if.hold);
      end
    end
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_clean_press();
    logic [3:0] exp_level, exp_press, exp_rel;
    a_if.in = 4'b0001;
    for (int e = 0; e <= 7; e++) begin
      @(posedge clk); #1;
      exp_level = (e >= 5) ? 4'b0001 : 4'b0000;
      exp_press = (e == 5) ? 4'b0001 : 4'b0000;
      tests++;
      if (a_if.level !== exp_level || a_if.press !== exp_press ||
          a_if.release_pulse !== 4'b0 || a_if.hold !== 4'b0) begin
        fails++;
        $display("FAIL clean_press edge %0d: level=%b press=%b rel=%b hold=%b, expected level=%b press=%b rel=0000 hold=0000",
                 e, a_if.level, a_if.press, a_if.release_pulse, a_if.hold, exp_level, exp_press);
      end
    end
    a_if.in = 4'b0000;
    for (int e = 0; e <= 7; e++) begin
      @(posedge clk); #1;
      exp_level = (e < 5) ? 4'b0001 : 4'b0000;
      exp_rel   = (e == 5) ? 4'b0001 : 4'b0000;
      tests++;
      if (a_if.level !== exp_level || a_if.press !== 4'b0 ||
          a_if.release_pulse !== exp_rel || a_if.hold !== 4'b0) begin
        fails++;
        $display("FAIL clean_release edge %0d: level=%b press=%b rel=%b hold=%b, expected level=%b press=0000 rel=%b hold=0000",
                 e, a_if.level, a_if.press, a_if.release_pulse, a_if.hold, exp_level, exp_rel);
      end
    end
  endtask

  task automatic test_glitch();
    logic [9:0] pat = 10'b0001110111;
    for (int e = 0; e < 16; e++) begin
      a_if.in = (e < 10) ? {2'b00, pat[e], 1'b0} : 4'b0000;
      @(posedge clk); #1;
      tests++;
      if (a_if.level !== 4'b0 || a_if.press !== 4'b0 || a_if.release_pulse !== 4'b0) begin
        fails++;
        $display("FAIL glitch edge %0d: level=%b press=%b rel=%b, expected all 0000",
                 e, a_if.level, a_if.press, a_if.release_pulse);
      end
    end
  endtask

  task automatic test_hold_repeat();
    logic [3:0] exp_level, exp_press, exp_rel, exp_hold_a, exp_hold_b;
    for (int e = 0; e <= 70; e++) begin
      a_if.in = (e < 60) ? 4'b0100 : 4'b0000;
      @(posedge clk); #1;
      exp_level  = (e >= 5 && e <= 64) ? 4'b0100 : 4'b0000;
      exp_press  = (e == 5) ? 4'b0100 : 4'b0000;
      exp_rel    = (e == 65) ? 4'b0100 : 4'b0000;
      exp_hold_a = (e == 25 || e == 33 || e == 41 || e == 49 || e == 57) ? 4'b0100 : 4'b0000;
      exp_hold_b = (e == 25) ? 4'b0100 : 4'b0000;
      tests++;
      if (a_if.level !== exp_level || a_if.press !== exp_press ||
          a_if.release_pulse !== exp_rel || a_if.hold !== exp_hold_a) begin
        fails++;
        $display("FAIL hold_repeat edge %0d: level=%b press=%b rel=%b hold=%b, expected %b %b %b %b",
                 e, a_if.level, a_if.press, a_if.release_pulse, a_if.hold,
                 exp_level, exp_press, exp_rel, exp_hold_a);
      end
      tests++;
      if (b_if.level !== exp_level || b_if.press !== exp_press ||
          b_if.release_pulse !== exp_rel || b_if.hold !== exp_hold_b) begin
        fails++;
        $display("FAIL hold_single edge %0d: level=%b press=%b rel=%b hold=%b, expected %b %b %b %b",
                 e, b_if.level, b_if.press, b_if.release_pulse, b_if.hold,
                 exp_level, exp_press, exp_rel, exp_hold_b);
      end
    end
  endtask

  task automatic test_active_low();
    logic [3:0] exp_level, exp_press, exp_rel;
    c_if.in = 4'h0;
    for (int e = 0; e <= 7; e++) begin
      @(posedge clk); #1;
      exp_level = (e >= 5) ? 4'hF : 4'h0;
      exp_press = (e == 5) ? 4'hF : 4'h0;
      tests++;
      if (c_if.level !== exp_level || c_if.press !== exp_press ||
          c_if.release_pulse !== 4'h0 || c_if.hold !== 4'h0) begin
        fails++;
        $display("FAIL active_low_press edge %0d: level=%h press=%h rel=%h hold=%h, expected level=%h press=%h rel=0 hold=0",
                 e, c_if.level, c_if.press, c_if.release_pulse, c_if.hold, exp_level, exp_press);
      end
    end
    c_if.in = 4'hF;
    for (int e = 0; e <= 7; e++) begin
      @(posedge clk); #1;
      exp_level = (e < 5) ? 4'hF : 4'h0;
      exp_rel   = (e == 5) ? 4'hF : 4'h0;
      tests++;
      if (c_if.level !== exp_level || c_if.press !== 4'h0 ||
          c_if.release_pulse !== exp_rel || c_if.hold !== 4'h0) begin
        fails++;
        $display("FAIL active_low_release edge %0d: level=%h press=%h rel=%h hold=%h, expected level=%h press=0 rel=%h hold=0",
                 e, c_if.level, c_if.press, c_if.release_pulse, c_if.hold, exp_level, exp_rel);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_level, exp_press;
    a_if.in = 4'b1000;
    repeat (8) @(posedge clk);
    #1;
    tests++;
    if (a_if.level !== 4'b1000) begin
      fails++;
      $display("FAIL reset_mid_pre: level=%b, expected 1000", a_if.level);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if (a_if.level !== 4'b0 || a_if.press !== 4'b0 || a_if.release_pulse !== 4'b0) begin
      fails++;
      $display("FAIL reset_mid_rst: level=%b press=%b rel=%b, expected all 0000",
               a_if.level, a_if.press, a_if.release_pulse);
    end
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      exp_level = (e >= 6) ? 4'b1000 : 4'b0000;
      exp_press = (e == 6) ? 4'b1000 : 4'b0000;
      tests++;
      if (a_if.level !== exp_level || a_if.press !== exp_press || a_if.release_pulse !== 4'b0) begin
        fails++;
        $display("FAIL reset_mid_repress edge %0d: level=%b press=%b rel=%b, expected level=%b press=%b rel=0000",
                 e, a_if.level, a_if.press, a_if.release_pulse, exp_level, exp_press);
      end
    end
    a_if.in = 4'b0000;
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    a_if.in = 4'h0;
    c_if.in = 4'hF;
    test_reset();
    test_clean_press();
    test_glitch();
    test_hold_repeat();
    test_active_low();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_debounce_array.md
Name: key_debounce_array

Overview:
- Parametrised multi-channel successor to the single-key debounce/one-shot.
- Per channel:
  - two-flop input synchroniser
  - symmetric debounce on both press and release
  - registered clean level output
  - one-cycle press and release pulses
  - long-press detection with optional auto-repeat
- Sits between raw board pushbuttons/switches and control logic (e.g. FFT demo start/mode keys).

Parameters:
- CHANNELS, 4: number of independent key inputs.
- DEBOUNCE_CYCLES, 15: consecutive synchronised samples that must differ from the current level before the level flips; must be >=1.
- ACTIVE_LOW, 0: 1 = raw input inverted before synchroniser, so pressed key reads 1 internally.
- HOLD_CYCLES, 1000: cycles of level=1 before first hold pulse; must be >=1.
- REPEAT_CYCLES, 200: interval between hold pulses after the first; must be >=1.
- REPEAT_EN, 1: 1 = hold repeats while pressed; 0 = single hold pulse per press.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in  in  CHANNELS  raw asynchronous key inputs, bit i = channel i.
- level  out  CHANNELS  debounced pressed state, registered.
- press  out  CHANNELS  one-cycle pulse on level 0->1.
- release  out  CHANNELS  one-cycle pulse on level 1->0.
- hold  out  CHANNELS  one-cycle pulse at long-press threshold and each repeat interval.

Behaviour:
- Reset (rst=1 at posedge):
  - level, press, release, hold, synchroniser flops and all counters go to 0.
  - No release pulse is generated by reset, even if level was 1.
- Input path:
  - x = in ^ {CHANNELS{ACTIVE_LOW}}.
  - s1 <= x; s2 <= s1 (two flops per channel, no reset-time metastability filter beyond these).
- Debounce counter, per channel:
  - cnt has width $clog2(DEBOUNCE_CYCLES+1).
  - At each edge, if s2 == level then cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1 then level <= s2 and cnt <= 0.
  - Else cnt <= cnt+1.
  - Any single sample matching level restarts the count (glitch rejection).
- Latency: a clean step on x captured at edge 0 causes level to flip after edge DEBOUNCE_CYCLES+1. The same applies to release.
- press/release:
  - Registered; asserted in the same cycle level first shows the new value.
  - Exactly one cycle wide; deasserted the next cycle.
  - press and release are never both high on a channel.
- Hold counter, per channel:
  - hcnt has width $clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1).
  - Cleared while level=0 and on the press cycle.
  - Increments each cycle while level=1.
  - hold pulses when level has been 1 for HOLD_CYCLES edges after the press edge (i.e. press at edge P gives hold after edge P+HOLD_CYCLES).
  - If REPEAT_EN: further pulses at P+HOLD_CYCLES+k*REPEAT_CYCLES, k>=1, implemented by reloading hcnt; the counter never wraps unchecked.
  - If !REPEAT_EN: hcnt saturates after the first pulse and no more hold pulses occur until the next press.
- Release mid-hold:
  - hold counting stops the cycle level falls.
  - No hold pulse on or after the release cycle.
- Channels are fully independent; simultaneous events on several channels produce simultaneous pulses.
- Reset mid-press: after rst deasserts with the key still held, a fresh press occurs DEBOUNCE_CYCLES+2 edges later.
- Unused/invalid parameter values (0 for any cycle count) are a synthesis-time error via generate-time check.

Test Plan:
- CHANNELS=4, DEBOUNCE_CYCLES=4, HOLD=20, REPEAT=8, REPEAT_EN=1, ACTIVE_LOW=0 unless stated.
- Clean press:
  - in[0] 0->1 before edge 0, held -> level[0]=1 and press[0]=1 after edge 5.
  - press[0]=0 after edge 6.
  - Other channels stay 0.
- Glitch rejection:
  - in[1] high for 3 cycles, low for 1, high for 3, then low -> level[1], press[1], release[1] never assert.
- Hold/repeat:
  - in[2] held 60 cycles -> press at P, hold pulses after edges P+20, P+28, P+36, P+44, P+52.
  - Release pulse DEBOUNCE_CYCLES+1 edges after in falls, with no hold afterwards.
  - With REPEAT_EN=0: single hold at P+20 only.
- Active-low and concurrency:
  - ACTIVE_LOW=1, in=4'hF idle, then in=4'h0 -> level=4'hF and press=4'hF in the same cycle after edge 5.
  - Returning to 4'hF -> release=4'hF after a further 5 edges.
- Reset mid-operation:
  - in[3] held, level[3]=1, assert rst 1 cycle -> level=0, release[3] stays 0.
  - After rst low, press[3] pulses 6 edges later.
